// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A valid/ready input handshake starts a conversion; out_valid pulses once when the result lands.
module bcd_convert_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic                  busy
);

    // Handshake: a word is taken on any posedge where in_valid && in_ready; in_ready
    // depends only on state, and the upstream must hold in_valid until it sees in_ready.
    localparam int BCDW = 4 * DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_bin;
    logic [BCDW-1:0]   r_acc;
    logic              r_ovf_acc;
    logic [CW-1:0]     r_cnt;
    logic [BCDW-1:0]   r_bcd;
    logic              r_ovf;
    logic              r_valid;

    logic [BCDW-1:0]   w_adj;
    logic [BCDW-1:0]   w_acc_shifted;
    logic              w_acc_msb;
    logic              w_accept;
    logic              w_last;

    // Add-3 correction per digit, no carry between digits.
    always_comb begin
        w_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            else
                w_adj[4*d +: 4] = r_acc[4*d +: 4];
        end
    end

    assign w_acc_shifted = {w_adj[BCDW-2:0], r_bin[WIDTH-1]};
    assign w_acc_msb     = w_adj[BCDW-1];

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == CNT_ONE) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bin     <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= 1'b0;
            if (w_accept) begin
                r_bin     <= in_data;
                r_acc     <= '0;
                r_ovf_acc <= 1'b0;
                r_cnt     <= CNT_INIT;
            end else if (r_state == SHIFT) begin
                r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
                r_acc     <= w_acc_shifted;
                r_ovf_acc <= r_ovf_acc | w_acc_msb;
                r_cnt     <= r_cnt - CNT_ONE;
                // Previous result stays visible until this final shift publishes the new one.
                if (w_last) begin
                    r_bcd   <= w_acc_shifted;
                    r_ovf   <= r_ovf_acc | w_acc_msb;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_bcd   = r_bcd;
    assign out_ovf   = r_ovf;

endmodule
